console_line_arbiter: RTL and testbench



---
 rtl/console_line_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_console_line_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_line_arbiter.sv
// Round-robin, line-granular arbiter that merges per-core UART character streams onto one console channel.
// Optional "[n] " line prefix is compiled in with CONSOLE_PREFIX_EN.
module console_line_arbiter #(
    parameter int unsigned N_SRC        = 2,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned LINE_TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_ch,
    output logic [N_SRC-1:0]     src_ready,
    output logic                 out_valid,
    output logic [7:0]           out_ch,
    input  logic                 out_ready,
    output logic [3:0]           grant_id,
    output logic [15:0]          drop_count
);
    localparam int unsigned SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned TW    = (LINE_TIMEOUT > 1) ? $clog2(LINE_TIMEOUT) : 1;
    localparam logic [7:0]  NEWLINE = 8'h0A;

`ifdef CONSOLE_PREFIX_EN
    typedef enum logic [1:0] {IDLE, STREAM, PREFIX} state_t;
`else
    typedef enum logic [0:0] {IDLE, STREAM} state_t;
`endif

    logic [7:0]       mem    [N_SRC][FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr [N_SRC];
    logic [AW-1:0]    rd_ptr [N_SRC];
    logic [CW-1:0]    count  [N_SRC];
    logic [N_SRC-1:0] full, empty, push, pop, drop;

    state_t           state, state_nx;
    logic [SEL_W-1:0] sel, sel_nx, ptr, ptr_nx, next_src;
    logic [TW-1:0]    tcnt, tcnt_nx;
    logic [N_SRC-1:0] mid_line, mid_nx;
    logic [3:0]       grant_nx;
    logic             any_req, pop_c;
    logic [7:0]       head;
    logic [4:0]       drop_pop;
    logic [16:0]      drop_sum;
`ifdef CONSOLE_PREFIX_EN
    logic [1:0]       pfx_idx, pfx_nx;
    logic [7:0]       hex_ch;
`endif

    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= N_SRC) s = s - N_SRC;
        return SEL_W'(s);
    endfunction

    // FIFO status and per-source push/drop decisions (pop never frees room the same cycle)
    always_comb begin
        drop_pop = '0;
        for (int i = 0; i < N_SRC; i++) begin
            full[i]  = (count[i] == CW'(FIFO_DEPTH));
            empty[i] = (count[i] == '0);
            push[i]  = src_valid[i] && !full[i];
            drop[i]  = src_valid[i] && full[i];
            drop_pop = drop_pop + 5'(drop[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            pop[i] = pop_c && (sel == SEL_W'(i));
        end
    end

    assign src_ready = ~full;
    assign head      = mem[sel][rd_ptr[sel]];
    assign drop_sum  = 17'(drop_count) + 17'(drop_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= src_ch[8*i +: 8];
        end
    end

    // First non-empty source searching upward from ptr+1; lowest offset wins
    always_comb begin
        next_src = ptr;
        any_req  = 1'b0;
        for (int k = N_SRC; k >= 1; k--) begin
            if (!empty[wrap_idx(ptr, k)]) begin
                next_src = wrap_idx(ptr, k);
                any_req  = 1'b1;
            end
        end
    end

`ifdef CONSOLE_PREFIX_EN
    assign hex_ch = (sel < SEL_W'(10)) ? (8'h30 + 8'(sel)) : (8'h37 + 8'(sel));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            ptr        <= SEL_W'(N_SRC - 1);
            tcnt       <= '0;
            mid_line   <= '0;
            grant_id   <= '0;
            drop_count <= '0;
`ifdef CONSOLE_PREFIX_EN
            pfx_idx    <= '0;
`endif
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            ptr        <= ptr_nx;
            tcnt       <= tcnt_nx;
            mid_line   <= mid_nx;
            grant_id   <= grant_nx;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`ifdef CONSOLE_PREFIX_EN
            pfx_idx    <= pfx_nx;
`endif
        end
    end

    // Grant FSM; output path is combinational from the granted FIFO head
    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        ptr_nx    = ptr;
        tcnt_nx   = tcnt;
        mid_nx    = mid_line;
        grant_nx  = grant_id;
        out_valid = 1'b0;
        out_ch    = '0;
        pop_c     = 1'b0;
`ifdef CONSOLE_PREFIX_EN
        pfx_nx    = pfx_idx;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_nx   = next_src;
                    ptr_nx   = next_src;
                    grant_nx = 4'(next_src);
                    tcnt_nx  = '0;
`ifdef CONSOLE_PREFIX_EN
                    pfx_nx   = '0;
                    state_nx = mid_line[next_src] ? STREAM : PREFIX;
`else
                    state_nx = STREAM;
`endif
                end
            end
            STREAM: begin
                out_valid = !empty[sel];
                out_ch    = out_valid ? head : '0;
                if (out_valid && out_ready) begin
                    pop_c   = 1'b1;
                    tcnt_nx = '0;
                    if (head == NEWLINE) begin
                        mid_nx[sel] = 1'b0;
                        state_nx    = IDLE;
                    end else begin
                        mid_nx[sel] = 1'b1;
                    end
                end else if (empty[sel]) begin
                    if (tcnt == TW'(LINE_TIMEOUT - 1)) begin
                        tcnt_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
            end
`ifdef CONSOLE_PREFIX_EN
            PREFIX: begin
                out_valid = 1'b1;
                tcnt_nx   = '0;
                case (pfx_idx)
                    2'd0:    out_ch = 8'h5B;
                    2'd1:    out_ch = hex_ch;
                    2'd2:    out_ch = 8'h5D;
                    default: out_ch = 8'h20;
                endcase
                if (out_ready) begin
                    pfx_nx = pfx_idx + 2'd1;
                    if (pfx_idx == 2'd3) state_nx = STREAM;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_console_line_arbiter.sv
// Scoreboard bench for console_line_arbiter (N_SRC=2, FIFO_DEPTH=8, short line timeout).
module tb_console_line_arbiter;
    localparam int L = 32;

    logic        clock, reset;
    logic [1:0]  src_valid;
    logic [15:0] src_ch;
    logic [1:0]  src_ready;
    logic        out_valid;
    logic [7:0]  out_ch;
    logic        out_ready;
    logic [3:0]  grant_id;
    logic [15:0] drop_count;

    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    logic [1:0]  exp_mid;
    int          checks, errors;

    console_line_arbiter #(.N_SRC(2), .FIFO_DEPTH(8), .LINE_TIMEOUT(L)) dut (
        .clock(clock), .reset(reset), .src_valid(src_valid), .src_ch(src_ch),
        .src_ready(src_ready), .out_valid(out_valid), .out_ch(out_ch),
        .out_ready(out_ready), .grant_id(grant_id), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    // Record every accepted console character
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) obs_q.push_back(out_ch);
    end

    // Expected console text for one source, including the line prefix when built in
    task automatic expect_str(input int s, input string str);
        for (int i = 0; i < str.len(); i++) begin
`ifdef CONSOLE_PREFIX_EN
            if (!exp_mid[s]) begin
                exp_q.push_back(8'h5B);
                exp_q.push_back(8'h30 + 8'(s));
                exp_q.push_back(8'h5D);
                exp_q.push_back(8'h20);
            end
`endif
            exp_q.push_back(str[i]);
            exp_mid[s] = (str[i] != 8'h0A);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1; src_valid = '0; src_ch = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_mid = '0; exp_q.delete(); obs_q.delete();
    endtask

    task automatic drive_two(input string s0, input string s1);
        int n;
        n = (s0.len() > s1.len()) ? s0.len() : s1.len();
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            src_valid[0] = (i < s0.len());
            src_ch[7:0]  = (i < s0.len()) ? s0[i] : 8'h00;
            src_valid[1] = (i < s1.len());
            src_ch[15:8] = (i < s1.len()) ? s1[i] : 8'h00;
        end
        @(posedge clock); #1;
        src_valid = '0;
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int c = 0; c < budget && obs_q.size() < n; c++) @(negedge clock);
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clock);
        checks += 5;
        if (src_ready !== 2'b11) begin errors++; $display("FAIL reset_src_ready: got %b expected 11", src_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_ch !== 8'h00) begin errors++; $display("FAIL reset_out_ch: got %h expected 00", out_ch); end
        if (grant_id !== 4'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    endtask

    task automatic test_single();
        logic [7:0] e, o;
        out_ready = 1'b1;
        expect_str(0, "hi\n");
        @(posedge clock); #1; src_valid = 2'b01; src_ch[7:0] = "h";
        @(posedge clock); #1; src_ch[7:0] = "i";
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat_early: got %b expected 0", out_valid); end
        @(posedge clock); #1; src_ch[7:0] = "\n";
        @(negedge clock);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_lat_valid: got %b expected 1", out_valid); end
        if (grant_id !== 4'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
        @(posedge clock); #1; src_valid = '0;
        wait_out(exp_q.size(), 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 8'hxx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL single_data: got %h expected %h", o, e); end
        end
        checks += 2;
        if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra: got %0d extra chars expected 0", obs_q.size()); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_interleave();
        logic [7:0] e, o;
        reset_dut();
        out_ready = 1'b1;
        expect_str(0, "AB\n"); expect_str(1, "CD\n");
        expect_str(0, "AB\n"); expect_str(1, "CD\n");
        drive_two("AB\n", "CD\n");
        wait_out(exp_q.size() / 2, 200);
        checks++;
        if (grant_id !== 4'd1) begin errors++; $display("FAIL interleave_grant: got %0d expected 1", grant_id); end
        drive_two("AB\n", "CD\n");
        wait_out(exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 8'hxx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL interleave_data: got %h expected %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL interleave_extra: got %0d extra chars expected 0", obs_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e, o;
        out_ready = 1'b0;
        expect_str(0, "abcdefg\n");
        drive_two("abcdefg\nXY", "");
        @(negedge clock);
        checks += 4;
        if (src_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_src_ready: got %b expected 0", src_ready[0]); end
        if (src_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_src_ready1: got %b expected 1", src_ready[1]); end
        if (drop_count !== 16'd2) begin errors++; $display("FAIL bp_drop_count: got %0d expected 2", drop_count); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled_valid: got %b expected 1", out_valid); end
        @(posedge clock); #1; out_ready = 1'b1;
        wait_out(exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 8'hxx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL bp_data: got %h expected %h", o, e); end
        end
        checks += 2;
        if (obs_q.size() != 0) begin errors++; $display("FAIL bp_extra: got %0d extra chars expected 0", obs_q.size()); end
        if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", src_ready[0]); end
    endtask

    task automatic test_timeout();
        logic [7:0] e, o;
        int nx;
        reset_dut();
        out_ready = 1'b1;
        expect_str(0, "x");
        nx = exp_q.size();
        expect_str(1, "y\n");
        drive_two("x", "y\n");
        repeat (L / 2) @(negedge clock);
        checks += 2;
        if (grant_id !== 4'd0) begin errors++; $display("FAIL timeout_hold_grant: got %0d expected 0", grant_id); end
        if (obs_q.size() != nx) begin errors++; $display("FAIL timeout_hold_count: got %0d expected %0d", obs_q.size(), nx); end
        wait_out(exp_q.size(), 4 * L + 50);
        checks++;
        if (grant_id !== 4'd1) begin errors++; $display("FAIL timeout_grant: got %0d expected 1", grant_id); end
        expect_str(0, "z\n");
        drive_two("z\n", "");
        wait_out(exp_q.size(), 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 8'hxx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL timeout_data: got %h expected %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL timeout_extra: got %0d extra chars expected 0", obs_q.size()); end
    endtask

    task automatic test_stall();
        logic [7:0] e, o, prev_ch;
        logic       prev_v, prev_r;
        int         n;
        string      s0, s1;
        s0 = "ok\n"; s1 = "go!\n";
        expect_str(1, s1); expect_str(0, s0);
        n = exp_q.size();
        out_ready = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_ch = '0;
        for (int cyc = 0; cyc < 400 && obs_q.size() < n; cyc++) begin
            @(posedge clock); #1;
            src_valid[0] = (cyc < s0.len());
            src_ch[7:0]  = (cyc < s0.len()) ? s0[cyc] : 8'h00;
            src_valid[1] = (cyc < s1.len());
            src_ch[15:8] = (cyc < s1.len()) ? s1[cyc] : 8'h00;
            out_ready = ~out_ready;
            @(negedge clock);
            if (prev_v && !prev_r) begin
                checks++;
                if (!(out_valid === 1'b1 && out_ch === prev_ch)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid %b ch %h expected valid 1 ch %h", out_valid, out_ch, prev_ch);
                end
            end
            prev_v = out_valid; prev_r = out_ready; prev_ch = out_ch;
        end
        src_valid = '0; out_ready = 1'b1;
        wait_out(n, 50);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 8'hxx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_data: got %h expected %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL stall_extra: got %0d extra chars expected 0", obs_q.size()); end
    endtask

    task automatic test_reset_midline();
        out_ready = 1'b0;
        drive_two("abc", "");
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pending: got %b expected 1", out_valid); end
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        if (src_ready !== 2'b11) begin errors++; $display("FAIL rst_mid_ready: got %b expected 11", src_ready); end
        if (grant_id !== 4'd0) begin errors++; $display("FAIL rst_mid_grant: got %0d expected 0", grant_id); end
        if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_mid_drops: got %0d expected 0", drop_count); end
        @(posedge clock); #1; reset = 1'b0; out_ready = 1'b1;
        exp_mid = '0; exp_q.delete(); obs_q.delete();
        repeat (10) @(negedge clock);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rst_mid_flush: got %0d chars expected 0", obs_q.size()); end
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1; src_valid = '0; src_ch = '0; out_ready = 1'b0;
        exp_mid = '0; checks = 0; errors = 0;
        test_reset();
        test_single();
        test_interleave();
        test_backpressure();
        test_timeout();
        test_stall();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
